// File: rtl/count_scheduler_if.sv
// ----------------------------------------------------------------------------
// count_scheduler_if
//   Bundles the requester-facing signals of count_scheduler.
//
//   req    [NREQ]        per-requester level request (held until done)
//   len    [NREQ*WIDTH]  run length of requester i at bits [i*WIDTH +: WIDTH]
//   gnt    [NREQ]        one-hot grant, all zero when idle
//   done   [NREQ]        one-cycle completion pulse to the granted requester
//   busy                 scheduler not idle
//   count  [WIDTH]       current counter value
//
//   modport master : requester side (drives req/len)
//   modport slave  : scheduler side (drives gnt/done/busy/count)
// ----------------------------------------------------------------------------
interface count_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    modport master (
        output req,
        output len,
        input  gnt,
        input  done,
        input  busy,
        input  count
    );

    modport slave (
        input  req,
        input  len,
        output gnt,
        output done,
        output busy,
        output count
    );
endinterface

// File: rtl/count_scheduler.sv
// ----------------------------------------------------------------------------
// count_scheduler
//   Shares one up-counter among NREQ requesters. An idle scheduler picks one
//   pending request, latches that requester's length, counts 0..len-1 (one
//   value per cycle), then issues a one-cycle done pulse together with the
//   last grant cycle and returns to idle. Dropping the request mid-run
//   cancels it without a done pulse.
//
//   Parameters
//     NREQ  : number of requesters (2..8)
//     WIDTH : count/length width in bits
//
//   Ports
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-low reset
//     bus    slave modport of count_scheduler_if (req/len in,
//                 gnt/done/busy/count out, all outputs registered)
//
//   Configuration macro
//     COUNT_SEQ_RR_EN : defined   -> round-robin arbitration, search starts
//                                    one past the last served requester
//                       undefined -> fixed priority, lowest index wins
// ----------------------------------------------------------------------------
module count_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    count_scheduler_if.slave    bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [NREQ-1:0]  done_q,  done_d;
    logic             busy_q,  busy_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q,   len_d;
    logic [IDXW-1:0]  win_q,   win_d;

    // Per-requester view of the packed length bus.
    logic [WIDTH-1:0] len_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
        assign len_arr[gi] = bus.len[gi*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Arbiter: combinational winner, only consumed in IDLE.
    // ------------------------------------------------------------------
    logic            any_req;
    logic [IDXW-1:0] win;

`ifdef COUNT_SEQ_RR_EN
    logic [IDXW-1:0] ptr_q, ptr_d;

    // Walk offsets from farthest to nearest so the last hit (the nearest
    // pending requester after ptr) is the one that sticks.
    always_comb begin
        int cand;
        cand    = 0;
        win     = '0;
        any_req = |bus.req;
        for (int off = NREQ; off >= 1; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) cand = cand - NREQ;
            if (bus.req[cand]) win = IDXW'(cand);
        end
    end
`else
    // Descending scan: the lowest asserted index is assigned last and wins.
    always_comb begin
        win     = '0;
        any_req = |bus.req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win = IDXW'(i);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        count_d = count_q;
        len_d   = len_q;
        win_d   = win_q;
`ifdef COUNT_SEQ_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = NREQ'(1) << win;
                    len_d   = len_arr[win];
                    win_d   = win;
                    count_d = '0;
                    busy_d  = 1'b1;
                    if (len_arr[win] == '0) begin
                        // Zero length: grant and done share one cycle.
                        state_d = ST_DONE;
                        done_d  = NREQ'(1) << win;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!bus.req[win_q]) begin
                    // Cancel: drop grant, keep count, no done pulse.
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
`ifdef COUNT_SEQ_RR_EN
                    ptr_d   = win_q;
`endif
                end else if (count_q == len_q - WIDTH'(1)) begin
                    // Last count value is held through the DONE cycle.
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
`ifdef COUNT_SEQ_RR_EN
                ptr_d   = win_q;
`endif
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            len_q   <= len_d;
            win_q   <= win_d;
        end
    end

`ifdef COUNT_SEQ_RR_EN
    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= IDXW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;

endmodule
